// File: rtl/keypad_scanner_if.sv
// Key event handshake between keypad_scanner (master) and the CPU I/O logic (slave).
interface keypad_scanner_if;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ack;
  logic       key_down;
  logic       overrun;

  modport master (
    output key_code,
    output key_valid,
    output key_down,
    output overrun,
    input  key_ack
  );

  modport slave (
    input  key_code,
    input  key_valid,
    input  key_down,
    input  overrun,
    output key_ack
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one row low per slot, samples synchronized columns,
// debounces over whole scan frames and reports one key code per press over a valid/ack
// handshake. Optional auto-repeat while held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scanner #(
  parameter logic [15:0] SCAN_DIV       = 16'd1000,
  parameter logic [7:0]  DEBOUNCE_SCANS = 8'd4
`ifdef KEYPAD_REPEAT_EN
  ,
  parameter logic [7:0]  REPEAT_DELAY   = 8'd50,
  parameter logic [7:0]  REPEAT_RATE    = 8'd10
`endif
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [3:0]             col_n,
  output logic [3:0]             row_n,
  keypad_scanner_if.master       kbus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_PRESSED,
    ST_RELEASE
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  col_s1_q, col_s1_d;
  logic [3:0]  col_s2_q, col_s2_d;
  logic [15:0] slot_cnt_q, slot_cnt_d;
  logic [1:0]  row_q, row_d;
  logic [3:0]  row_n_q, row_n_d;
  logic        hit_acc_q, hit_acc_d;
  logic [3:0]  code_acc_q, code_acc_d;
  logic [3:0]  cand_q, cand_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  key_code_q, key_code_d;
  logic        key_valid_q, key_valid_d;
  logic        key_down_q, key_down_d;
  logic        overrun_q, overrun_d;
`ifdef KEYPAD_REPEAT_EN
  logic [7:0]  rep_cnt_q, rep_cnt_d;
  logic        rep_armed_q, rep_armed_d;
`endif

  logic        slot_end;
  logic        frame_end;
  logic        frame_hit;
  logic [3:0]  frame_code;
  logic [3:0]  closed;
  logic        row_hit;
  logic [1:0]  row_col;
  logic        emit;
  logic [3:0]  emit_code;

  // Next-state logic: scan timing, frame accumulation, debounce FSM and handshake.
  always_comb begin
    state_d     = state_q;
    col_s1_d    = col_n;
    col_s2_d    = col_s1_q;
    slot_cnt_d  = slot_cnt_q + 16'd1;
    row_d       = row_q;
    row_n_d     = row_n_q;
    hit_acc_d   = hit_acc_q;
    code_acc_d  = code_acc_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = key_valid_q;
    overrun_d   = overrun_q;
`ifdef KEYPAD_REPEAT_EN
    rep_cnt_d   = rep_cnt_q;
    rep_armed_d = rep_armed_q;
`endif
    frame_end   = 1'b0;
    frame_hit   = 1'b0;
    frame_code  = 4'd0;
    emit        = 1'b0;
    emit_code   = cand_q;

    // Lowest closed column in the currently driven row.
    closed  = ~col_s2_q;
    row_hit = |closed;
    if (closed[0])      row_col = 2'd0;
    else if (closed[1]) row_col = 2'd1;
    else if (closed[2]) row_col = 2'd2;
    else                row_col = 2'd3;

    slot_end = (slot_cnt_q == SCAN_DIV - 16'd1);
    if (slot_end) begin
      slot_cnt_d = 16'd0;
      row_d      = row_q + 2'd1;
      row_n_d    = ~(4'b0001 << row_d);
      // Row 0 opens a new frame; later rows only matter if nothing lower was closed.
      if (row_q == 2'd0) begin
        hit_acc_d  = row_hit;
        code_acc_d = {2'd0, row_col};
      end else if (!hit_acc_q && row_hit) begin
        hit_acc_d  = 1'b1;
        code_acc_d = {row_q, row_col};
      end
      if (row_q == 2'd3) begin
        frame_end  = 1'b1;
        frame_hit  = hit_acc_q | row_hit;
        frame_code = hit_acc_q ? code_acc_q : {2'd3, row_col};
      end
    end

    if (frame_end) begin
      unique case (state_q)
        ST_IDLE: begin
          if (frame_hit) begin
            cand_d = frame_code;
            cnt_d  = 8'd1;
            if (DEBOUNCE_SCANS == 8'd1) begin
              state_d   = ST_PRESSED;
              emit      = 1'b1;
              emit_code = frame_code;
            end else begin
              state_d = ST_DEBOUNCE;
            end
          end
        end
        ST_DEBOUNCE: begin
          if (frame_hit && frame_code == cand_q) begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_q + 8'd1 == DEBOUNCE_SCANS) begin
              state_d = ST_PRESSED;
              emit    = 1'b1;
            end
          end else begin
            state_d = ST_IDLE;
            cnt_d   = 8'd0;
          end
        end
        ST_PRESSED: begin
          // A single quiet frame is already a full release when one frame is enough.
          if (!frame_hit) begin
            cnt_d   = (DEBOUNCE_SCANS == 8'd1) ? 8'd0 : 8'd1;
            state_d = (DEBOUNCE_SCANS == 8'd1) ? ST_IDLE : ST_RELEASE;
          end
`ifdef KEYPAD_REPEAT_EN
          else begin
            rep_cnt_d = rep_cnt_q + 8'd1;
            if (( rep_armed_q && rep_cnt_q + 8'd1 == REPEAT_RATE) ||
                (!rep_armed_q && rep_cnt_q + 8'd1 == REPEAT_DELAY)) begin
              emit        = 1'b1;
              rep_cnt_d   = 8'd0;
              rep_armed_d = 1'b1;
            end
          end
`endif
        end
        ST_RELEASE: begin
          if (!frame_hit) begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_q + 8'd1 == DEBOUNCE_SCANS) begin
              state_d = ST_IDLE;
              cnt_d   = 8'd0;
            end
          end else if (frame_code == cand_q) begin
            state_d = ST_PRESSED;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = 8'd0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

`ifdef KEYPAD_REPEAT_EN
    // Repeat timing restarts on every fresh entry into PRESSED.
    if (state_d == ST_PRESSED && state_q != ST_PRESSED) begin
      rep_cnt_d   = 8'd0;
      rep_armed_d = 1'b0;
    end else if (state_d != ST_PRESSED) begin
      rep_cnt_d   = 8'd0;
      rep_armed_d = 1'b0;
    end
`endif

    // An emit always wins over a same-edge ack; overrun only grows on an unacked overwrite.
    if (emit) begin
      key_code_d  = emit_code;
      key_valid_d = 1'b1;
      if (key_valid_q && !kbus.key_ack) overrun_d = 1'b1;
    end else if (kbus.key_ack && key_valid_q) begin
      key_valid_d = 1'b0;
      overrun_d   = 1'b0;
    end

    key_down_d = (state_d == ST_PRESSED) || (state_d == ST_RELEASE);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      col_s1_q    <= 4'hF;
      col_s2_q    <= 4'hF;
      slot_cnt_q  <= 16'd0;
      row_q       <= 2'd0;
      row_n_q     <= 4'b1110;
      hit_acc_q   <= 1'b0;
      code_acc_q  <= 4'd0;
      cand_q      <= 4'd0;
      cnt_q       <= 8'd0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_q   <= 8'd0;
      rep_armed_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      col_s1_q    <= col_s1_d;
      col_s2_q    <= col_s2_d;
      slot_cnt_q  <= slot_cnt_d;
      row_q       <= row_d;
      row_n_q     <= row_n_d;
      hit_acc_q   <= hit_acc_d;
      code_acc_q  <= code_acc_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_down_q  <= key_down_d;
      overrun_q   <= overrun_d;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_q   <= rep_cnt_d;
      rep_armed_q <= rep_armed_d;
`endif
    end
  end

  assign row_n          = row_n_q;
  assign kbus.key_code  = key_code_q;
  assign kbus.key_valid = key_valid_q;
  assign kbus.key_down  = key_down_q;
  assign kbus.overrun   = overrun_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Testbench for keypad_scanner: SCAN_DIV=4, DEBOUNCE_SCANS=3 (16-clock frame).
// A behavioural keypad matrix drives col_n from row_n and the set of held keys.
module tb_keypad_scanner;

  logic        clk;
  logic        reset;
  logic [3:0]  col_n;
  logic [3:0]  row_n;
  logic [15:0] keys;

  int vectors;
  int miscompares;
  logic [3:0] exp_q[$];

  keypad_scanner_if kif ();

  keypad_scanner #(
    .SCAN_DIV       (16'd4),
    .DEBOUNCE_SCANS (8'd3)
`ifdef KEYPAD_REPEAT_EN
    ,
    .REPEAT_DELAY   (8'd4),
    .REPEAT_RATE    (8'd2)
`endif
  ) dut (
    .clk   (clk),
    .reset (reset),
    .col_n (col_n),
    .row_n (row_n),
    .kbus  (kif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad matrix: a held key pulls its column low while its row is driven low.
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_n[r] && keys[r*4 + c]) col_n[c] = 1'b0;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int budget, output bit ok, output int used);
    used = 0;
    while (!kif.key_valid && used < budget) begin
      tick(1);
      used++;
    end
    ok = kif.key_valid;
  endtask

  task automatic go_idle();
    keys = 16'h0;
    tick(100);
  endtask

  task automatic test_reset();
    logic [3:0] exp_row;
    bit bad_flags;
    reset = 1'b0;
    keys = 16'h0;
    kif.key_ack = 1'b0;
    tick(3);
    vectors++;
    if (row_n !== 4'b1110 || kif.key_code !== 4'h0 || kif.key_valid !== 1'b0 ||
        kif.key_down !== 1'b0 || kif.overrun !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_state: row_n=%b code=%h valid=%b down=%b ovr=%b, want 1110 0 0 0 0",
               row_n, kif.key_code, kif.key_valid, kif.key_down, kif.overrun);
    end
    reset = 1'b1;
    bad_flags = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      tick(1);
      exp_row = ~(4'b0001 << ((k / 4) % 4));
      vectors++;
      if (row_n !== exp_row) begin
        miscompares++;
        $display("[TB] FAIL row_scan k=%0d: row_n=%b want %b", k, row_n, exp_row);
      end
      if (kif.key_valid !== 1'b0 || kif.key_down !== 1'b0) bad_flags = 1'b1;
    end
    vectors++;
    if (bad_flags) begin
      miscompares++;
      $display("[TB] FAIL idle_flags: valid/down asserted during idle scan, want 0");
    end
  endtask

  task automatic test_single_press();
    bit ok;
    int used, elapsed, fall;
    bit extra;
    logic [3:0] exp;
    keys = 16'h0200;
    exp_q.push_back(4'h9);
    wait_valid(80, ok, used);
    elapsed = used;
    exp = exp_q.pop_front();
    vectors++;
    if (!ok || kif.key_code !== exp) begin
      miscompares++;
      $display("[TB] FAIL press_code: valid=%b code=%h want 1 %h", kif.key_valid, kif.key_code, exp);
    end
    vectors++;
    if (kif.key_down !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL press_down: key_down=%b want 1", kif.key_down);
    end
    tick(10);
    elapsed += 10;
    vectors++;
    if (kif.key_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL valid_hold: key_valid=%b want 1 before ack", kif.key_valid);
    end
    kif.key_ack = 1'b1;
    tick(1);
    kif.key_ack = 1'b0;
    elapsed++;
    vectors++;
    if (kif.key_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL ack_clear: key_valid=%b want 0", kif.key_valid);
    end
    extra = 1'b0;
    while (elapsed < 150) begin
      tick(1);
      elapsed++;
      if (kif.key_valid) extra = 1'b1;
    end
    keys = 16'h0;
    fall = 0;
    while (kif.key_down && fall < 100) begin
      tick(1);
      fall++;
      if (kif.key_valid) extra = 1'b1;
    end
    vectors++;
    if (extra) begin
      miscompares++;
      $display("[TB] FAIL single_event: extra key_valid seen, want exactly one event");
    end
    vectors++;
    if (kif.key_down !== 1'b0 || fall < 32 || fall > 80) begin
      miscompares++;
      $display("[TB] FAIL release_time: down=%b after %0d clks, want 0 within 32..80", kif.key_down, fall);
    end
  endtask

  task automatic test_glitch();
    bit seen;
    seen = 1'b0;
    keys = 16'h0040;
    for (int i = 0; i < 16; i++) begin
      tick(1);
      if (kif.key_valid || kif.key_down) seen = 1'b1;
    end
    keys = 16'h0;
    for (int i = 0; i < 120; i++) begin
      tick(1);
      if (kif.key_valid || kif.key_down) seen = 1'b1;
    end
    vectors++;
    if (seen) begin
      miscompares++;
      $display("[TB] FAIL glitch_reject: short press produced valid/down, want none");
    end
  endtask

  task automatic test_overrun();
    bit ok;
    int used;
    logic [3:0] exp;
    keys = 16'h0020;
    exp_q.push_back(4'h5);
    wait_valid(80, ok, used);
    exp = exp_q.pop_front();
    vectors++;
    if (!ok || kif.key_code !== exp) begin
      miscompares++;
      $display("[TB] FAIL first_code: valid=%b code=%h want 1 %h", kif.key_valid, kif.key_code, exp);
    end
    keys = 16'h0;
    used = 0;
    while (kif.key_down && used < 100) begin
      tick(1);
      used++;
    end
    keys = 16'h0040;
    exp_q.push_back(4'h6);
    used = 0;
    while (kif.key_code !== 4'h6 && used < 100) begin
      tick(1);
      used++;
    end
    exp = exp_q.pop_front();
    vectors++;
    if (kif.key_code !== exp || kif.key_valid !== 1'b1 || kif.overrun !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL overrun_set: code=%h valid=%b ovr=%b want %h 1 1",
               kif.key_code, kif.key_valid, kif.overrun, exp);
    end
    keys = 16'h0;
    kif.key_ack = 1'b1;
    tick(1);
    kif.key_ack = 1'b0;
    vectors++;
    if (kif.key_valid !== 1'b0 || kif.overrun !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL overrun_ack: valid=%b ovr=%b want 0 0", kif.key_valid, kif.overrun);
    end
  endtask

  task automatic test_priority_and_reset();
    bit ok;
    int used;
    logic [3:0] exp;
    keys = 16'h0018;
    exp_q.push_back(4'h3);
    wait_valid(80, ok, used);
    exp = exp_q.pop_front();
    vectors++;
    if (!ok || kif.key_code !== exp) begin
      miscompares++;
      $display("[TB] FAIL priority_code: valid=%b code=%h want 1 %h", kif.key_valid, kif.key_code, exp);
    end
    tick(5);
    reset = 1'b0;
    tick(1);
    vectors++;
    if (row_n !== 4'b1110 || kif.key_code !== 4'h0 || kif.key_valid !== 1'b0 ||
        kif.key_down !== 1'b0 || kif.overrun !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midpress_reset: row_n=%b code=%h valid=%b down=%b ovr=%b, want 1110 0 0 0 0",
               row_n, kif.key_code, kif.key_valid, kif.key_down, kif.overrun);
    end
    keys = 16'h0;
    tick(2);
    reset = 1'b1;
  endtask

  task automatic test_repeat();
    int cyc, nev, last, rel_cyc;
    bit bad_code, bad_gap, late;
    cyc = 0; nev = 0; last = 0; rel_cyc = 0;
    bad_code = 1'b0; bad_gap = 1'b0; late = 1'b0;
    keys = 16'h0400;
    for (int i = 0; i < 460; i++) begin
      if (i == 320) begin
        keys = 16'h0;
        rel_cyc = cyc;
      end
      tick(1);
      cyc++;
      if (kif.key_ack) begin
        kif.key_ack = 1'b0;
      end else if (kif.key_valid) begin
        nev++;
        if (kif.key_code !== 4'hA) bad_code = 1'b1;
        if (nev == 2 && cyc - last != 64) bad_gap = 1'b1;
        if (nev > 2 && cyc - last != 32) bad_gap = 1'b1;
        if (i >= 380) late = 1'b1;
        last = cyc;
        kif.key_ack = 1'b1;
      end
    end
    kif.key_ack = 1'b0;
    vectors++;
    if (bad_code) begin
      miscompares++;
      $display("[TB] FAIL repeat_code: an event carried a code other than A");
    end
    vectors++;
    if (late || kif.key_down !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL repeat_stop: late=%b down=%b after release at %0d, want 0 0", late, kif.key_down, rel_cyc);
    end
`ifdef KEYPAD_REPEAT_EN
    vectors++;
    if (bad_gap || nev < 5) begin
      miscompares++;
      $display("[TB] FAIL repeat_timing: events=%0d gap_error=%b, want >=5 with gaps 64 then 32", nev, bad_gap);
    end
`else
    vectors++;
    if (nev != 1 || bad_gap) begin
      miscompares++;
      $display("[TB] FAIL no_repeat: events=%0d want 1", nev);
    end
`endif
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    keys = 16'h0;
    reset = 1'b0;
    kif.key_ack = 1'b0;
    test_reset();
    go_idle();
    test_single_press();
    go_idle();
    test_glitch();
    go_idle();
    test_overrun();
    go_idle();
    test_priority_and_reset();
    go_idle();
    test_repeat();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
